// File: rtl/tick_stream_arbiter_if.sv
// Merged tick stream from the arbiter to the book builder.
//   tick_price/qty/is_buy : tick payload
//   tick_src              : originating source index (0 = feed A, 1 = feed B)
//   tick_valid            : payload valid, held until accepted
//   tick_ready            : consumer accepts when high together with valid
interface tick_stream_arbiter_if;
  logic [31:0] tick_price;
  logic [31:0] tick_qty;
  logic        tick_is_buy;
  logic        tick_src;
  logic        tick_valid;
  logic        tick_ready;

  modport master (
    output tick_price, tick_qty, tick_is_buy, tick_src, tick_valid,
    input  tick_ready
  );

  modport slave (
    input  tick_price, tick_qty, tick_is_buy, tick_src, tick_valid,
    output tick_ready
  );
endinterface

// File: rtl/tick_stream_arbiter.sv
// Merges two single-cycle tick strobes into one valid/ready stream.
// Each source is absorbed by a FIFO; a round-robin arbiter drains the FIFOs
// into a single registered output stage.
//   clk, rst_n            : clock, async active-low reset
//   s0_tick_*, s1_tick_*  : per-source tick payload and strobe (no backpressure)
//   cfg_src_en            : bit i = 0 ignores source i input
//   clr_stats             : one-cycle pulse clearing drop counters and flags
//   m                     : merged output stream (master side)
//   drop_cnt0/1           : saturating count of ticks lost to a full FIFO
//   ovf_flag              : sticky per-source drop indication
module tick_stream_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             s0_tick_price,
  input  logic [31:0]             s0_tick_qty,
  input  logic                    s0_tick_is_buy,
  input  logic                    s0_tick_valid,
  input  logic [31:0]             s1_tick_price,
  input  logic [31:0]             s1_tick_qty,
  input  logic                    s1_tick_is_buy,
  input  logic                    s1_tick_valid,
  input  logic [1:0]              cfg_src_en,
  input  logic                    clr_stats,
  tick_stream_arbiter_if.master   m,
  output logic [CNT_W-1:0]        drop_cnt0,
  output logic [CNT_W-1:0]        drop_cnt1,
  output logic [1:0]              ovf_flag
);

  localparam int unsigned DATA_W = 65;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  // FIFO storage and state
  logic [DATA_W-1:0] mem_q      [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q   [2];
  logic [PTR_W-1:0]  wr_ptr_d   [2];
  logic [PTR_W-1:0]  rd_ptr_q   [2];
  logic [PTR_W-1:0]  rd_ptr_d   [2];
  logic [FILL_W-1:0] fill_q     [2];
  logic [FILL_W-1:0] fill_d     [2];

  // Statistics
  logic [CNT_W-1:0]  drop_cnt_q [2];
  logic [CNT_W-1:0]  drop_cnt_d [2];
  logic [1:0]        ovf_q, ovf_d;

  // Arbiter and output stage
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;

  // Combinational control
  logic [DATA_W-1:0] entry_in [2];
  logic [1:0]        push_req;
  logic [1:0]        push_ok;
  logic [1:0]        drop;
  logic [1:0]        nonempty;
  logic [1:0]        pop;
  logic              out_free;
  logic              grant_vld;
  logic              grant_src;

  assign entry_in[0] = {s0_tick_is_buy, s0_tick_qty, s0_tick_price};
  assign entry_in[1] = {s1_tick_is_buy, s1_tick_qty, s1_tick_price};
  assign push_req    = {s1_tick_valid, s0_tick_valid} & cfg_src_en;

  // Round-robin grant on start-of-cycle occupancy; only when the output can load
  always_comb begin
    nonempty[0] = (fill_q[0] != '0);
    nonempty[1] = (fill_q[1] != '0);
    out_free    = !out_valid_q || m.tick_ready;
    grant_vld   = out_free && (nonempty != 2'b00);
    // With a single non-empty FIFO, nonempty[1] names it directly
    grant_src   = (nonempty == 2'b11) ? ~last_grant_q : nonempty[1];
    pop[0]      = grant_vld && !grant_src;
    pop[1]      = grant_vld &&  grant_src;
  end

  // FIFO pointers, fill levels and drop accounting
  always_comb begin
    push_ok = '0;
    drop    = '0;
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i]   = wr_ptr_q[i];
      rd_ptr_d[i]   = rd_ptr_q[i];
      fill_d[i]     = fill_q[i];
      drop_cnt_d[i] = drop_cnt_q[i];

      // A full FIFO still accepts when it is popped in the same cycle
      push_ok[i] = push_req[i] && ((fill_q[i] < FILL_W'(FIFO_DEPTH)) || pop[i]);
      drop[i]    = push_req[i] && !push_ok[i];

      if (push_ok[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (pop[i])     rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);

      if (push_ok[i] && !pop[i])      fill_d[i] = fill_q[i] + FILL_W'(1);
      else if (!push_ok[i] && pop[i]) fill_d[i] = fill_q[i] - FILL_W'(1);

      // Clear wins over a same-cycle drop
      if (clr_stats)
        drop_cnt_d[i] = '0;
      else if (drop[i] && (drop_cnt_q[i] != {CNT_W{1'b1}}))
        drop_cnt_d[i] = drop_cnt_q[i] + CNT_W'(1);
    end
    ovf_d = clr_stats ? 2'b00 : (ovf_q | drop);
  end

  // Output register: load on grant, invalidate when free and idle, else hold
  always_comb begin
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      out_data_d   = mem_q[grant_src][rd_ptr_q[grant_src]];
      out_src_d    = grant_src;
      out_valid_d  = 1'b1;
      last_grant_d = grant_src;
    end else if (out_free) begin
      out_valid_d  = 1'b0;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by fill_q
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= entry_in[i];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        fill_q[i]     <= '0;
        drop_cnt_q[i] <= '0;
      end
      ovf_q        <= 2'b00;
      last_grant_q <= 1'b1;
      out_data_q   <= '0;
      out_src_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i]   <= wr_ptr_d[i];
        rd_ptr_q[i]   <= rd_ptr_d[i];
        fill_q[i]     <= fill_d[i];
        drop_cnt_q[i] <= drop_cnt_d[i];
      end
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign m.tick_price  = out_data_q[31:0];
  assign m.tick_qty    = out_data_q[63:32];
  assign m.tick_is_buy = out_data_q[64];
  assign m.tick_src    = out_src_q;
  assign m.tick_valid  = out_valid_q;

  assign drop_cnt0 = drop_cnt_q[0];
  assign drop_cnt1 = drop_cnt_q[1];
  assign ovf_flag  = ovf_q;

endmodule

// File: doc/tick_stream_arbiter.md
Name: tick_stream_arbiter

Overview:
- Merges decoded tick streams from two parser shims (feed A = src 0, feed B = src 1) into the single tick input of the book builder.
- Shim outputs are single-cycle pulses with no backpressure, so each source is absorbed by a small FIFO.
- A round-robin arbiter drains the FIFOs into one registered valid/ready output stage.
- Per-source drop counters and overflow flags, plus a source-enable mask, are exposed for configuration and monitoring.

Parameters:
- FIFO_DEPTH, 4, entries per source FIFO; power of two, 2..16.
- CNT_W, 16, width of each saturating drop counter.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- s0_tick_price  input  32  source 0 price.
- s0_tick_qty  input  32  source 0 quantity.
- s0_tick_is_buy  input  1  source 0 side; 1 = buy.
- s0_tick_valid  input  1  source 0 tick strobe, one tick per asserted cycle.
- s1_tick_price / s1_tick_qty / s1_tick_is_buy / s1_tick_valid  input  32/32/1/1  same fields for source 1.
- cfg_src_en  input  2  per-source enable; bit i = 0 ignores source i input.
- clr_stats  input  1  one-cycle pulse clearing counters and flags.
- m_tick_price  output  32  merged price.
- m_tick_qty  output  32  merged quantity.
- m_tick_is_buy  output  1  merged side.
- m_tick_src  output  1  originating source index.
- m_tick_valid  output  1  merged tick valid.
- m_tick_ready  input  1  book builder accepts when high with valid.
- drop_cnt0, drop_cnt1  output  CNT_W  ticks lost to a full FIFO, per source.
- ovf_flag  output  2  sticky bit i set when source i dropped a tick.

Behaviour:
- Reset (async assert, sync release): FIFOs empty; all m_* outputs 0; drop counters 0; ovf_flag 0; last_grant = 1, so src 0 wins the first contention.
- FIFO entry is {is_buy, qty, price}, 65 bits. A push happens when sN_tick_valid=1 and cfg_src_en[N]=1.
- Disabled source: input ignored and not counted as a drop. Entries already queued still drain.
- Full condition: a push is accepted if count<FIFO_DEPTH at the start of the cycle, or if the same FIFO is popped in that cycle (count unchanged).
- Otherwise the tick is dropped: drop_cntN increments, saturating at 2^CNT_W-1, and ovf_flag[N] sets.
- clr_stats zeroes counters and flags. It takes precedence over a same-cycle drop, so the result is 0.
- Output stage is one register. It is "free" when m_tick_valid=0 or m_tick_ready=1.
- When free, arbitration is combinational on FIFO non-empty at the start of the cycle:
  - both non-empty: grant the source != last_grant;
  - one non-empty: grant it;
  - none: no grant.
- On a grant: pop the granted FIFO, load the output register, set m_tick_src, set m_tick_valid=1, and set last_grant = granted source.
- When free with no grant, m_tick_valid <= 0 and data is held.
- When m_tick_valid=1 and m_tick_ready=0, all m_* outputs hold stable. Neither FIFO is popped and last_grant is unchanged.
- Latency: a tick strobed in cycle N into an empty FIFO, with a free output, appears with m_tick_valid=1 in cycle N+2. Cycle N+1 is the FIFO write; no write-through path exists.
- Throughput: one tick per cycle sustained while m_tick_ready=1. Under sustained contention the two sources alternate strictly.
- Ordering: ticks within one source are delivered in arrival order. No ordering guarantee exists between sources.
- Reset asserted mid-operation: all queued ticks are lost and outputs return to reset values immediately.

Test Plan:
- Single tick: s0 price=0x64, qty=5, is_buy=1 pulsed in cycle 10, ready=1 -> m_tick_valid=1 in cycle 12 with price 0x64, qty 5, is_buy 1, src 0; valid=0 in cycle 13.
- Contention: s0 and s1 each strobe 3 ticks on consecutive cycles, ready=1 -> output order src 0,1,0,1,0,1 with each source's data in order; 6 consecutive valid cycles.
- Backpressure/overflow (FIFO_DEPTH=4): ready=0, s1 strobes 6 ticks -> first tick held in output register, 4 queued, 1 dropped; drop_cnt1=1, ovf_flag=2'b10.
- Backpressure drain: ready then raised -> the 5 retained ticks emerge in order; output stays stable while ready=0.
- Full plus pop: s0 FIFO full, ready=1, s0 strobes in the same cycle -> tick accepted, drop_cnt0 unchanged.
- Enable and clear: cfg_src_en=2'b01 with s1 strobing -> no s1 output, drop_cnt1 unchanged. clr_stats pulsed in the same cycle as an overflow drop -> counter reads 0.
- Reset mid-stream: rst_n low for 1 cycle while both FIFOs hold 3 entries -> m_tick_valid=0 immediately; no stale ticks emitted after release.
